sram_bus_arbiter: RTL

//  Shares the single SRAM I/O bus (ReadEnable/WriteEnable/ByteEnable/Address/WriteData/ReadData) between two requesters.

---
 rtl/sram_bus_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// Two-port arbiter for the shared SRAM I/O bus: round-robin grant, fixed-length
// bus access, registered read data and a one-cycle ack per completed access.
module sram_bus_arbiter #(
  parameter int ACC_CYCLES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReq0,
  input  logic        iReq1,
  input  logic        iWe0,
  input  logic        iWe1,
  input  logic [3:0]  iBE0,
  input  logic [3:0]  iBE1,
  input  logic [31:0] iAddr0,
  input  logic [31:0] iAddr1,
  input  logic [31:0] iWData0,
  input  logic [31:0] iWData1,
  output logic        oAck0,
  output logic        oAck1,
  output logic [31:0] oRData0,
  output logic [31:0] oRData1,
  output logic        oReadEnable,
  output logic        oWriteEnable,
  output logic [3:0]  oByteEnable,
  output logic [31:0] oAddress,
  output logic [31:0] oWriteData,
  input  logic [31:0] iReadData,
  output logic [1:0]  oDbgState
);

  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic          gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          re_q, re_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;
  logic          pick;

  // Handshake: a requester holds iReqN (and its fields) high until oAckN pulses;
  // the arbiter samples requests only in IDLE, so a grant is never revoked.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b1;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      re_q     <= re_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // On a tie the port that did not win last time is chosen.
  assign pick = (iReq0 && iReq1) ? ~rr_q : iReq1;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    re_d     = re_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      S_IDLE: begin
        if (iReq0 || iReq1) begin
          rr_d    = pick;
          gnt_d   = pick;
          cnt_d   = CNT_LOAD;
          re_d    = pick ? ~iWe1 : ~iWe0;
          we_d    = pick ? iWe1 : iWe0;
          be_d    = pick ? iBE1 : iBE0;
          addr_d  = pick ? iAddr1 : iAddr0;
          wdata_d = pick ? iWData1 : iWData0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (re_q) begin
            if (gnt_q) rdata1_d = iReadData;
            else       rdata0_d = iReadData;
          end
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          re_d    = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          addr_d  = '0;
          wdata_d = '0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign oAck0        = ack0_q;
  assign oAck1        = ack1_q;
  assign oRData0      = rdata0_q;
  assign oRData1      = rdata1_q;
  assign oReadEnable  = re_q;
  assign oWriteEnable = we_q;
  assign oByteEnable  = be_q;
  assign oAddress     = addr_q;
  assign oWriteData   = wdata_q;
  assign oDbgState    = state_q;

endmodule
